// File: rtl/countdown_timer_core_if.sv
// countdown_timer_core_if: command/preset inputs and BCD display/status outputs of the countdown timer
// master: command source and display sink; slave: the timer core
interface countdown_timer_core_if;
  logic load, start, pause, cancel;
  logic [3:0] ld_mD, ld_mU, ld_sD, ld_sU;
  logic [3:0] mDecimal, mUnit, sDecimal, sUnit;
  logic [2:0] state_o;
  logic done, alarm;
  modport master(
    output load, start, pause, cancel, ld_mD, ld_mU, ld_sD, ld_sU,
    input mDecimal, mUnit, sDecimal, sUnit, state_o, done, alarm
  );
  modport slave(
    input load, start, pause, cancel, ld_mD, ld_mU, ld_sD, ld_sU,
    output mDecimal, mUnit, sDecimal, sUnit, state_o, done, alarm
  );
endinterface

// File: rtl/countdown_timer_core.sv
// countdown_timer_core: mm:ss BCD countdown timer with IDLE/RUN/PAUSE/DONE control FSM
// clk: rising-edge clock; reset: asynchronous, active-low
// bus (slave): load/start/pause/cancel pulses and ld_* preset digits in;
//   mDecimal/mUnit/sDecimal/sUnit digits, state_o, done pulse and alarm out (all registered)
// TIMER_ALARM_EN: when defined, DONE drives a toggling alarm for ALARM_SEC ticks; otherwise alarm is 0
module countdown_timer_core #(
  parameter int TICK_DIV = 25_000_000,
  parameter int ALARM_SEC = 5
) (
  input logic clk,
  input logic reset,
  countdown_timer_core_if.slave bus
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2 - 1);
`ifdef TIMER_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd2, PAUSE = 3'd3, DONE = 3'd4} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, pre, pre_n, ld, dec;
  logic [PW-1:0] presc, presc_n;
  logic [AW-1:0] acnt, acnt_n;
  logic done_q, done_n, alarm_q, alarm_n, tick;
  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] m);
    return d > m ? m : d;
  endfunction
  assign ld = {clamp(bus.ld_mD, 4'd9), clamp(bus.ld_mU, 4'd9), clamp(bus.ld_sD, 4'd5), clamp(bus.ld_sU, 4'd9)};
  // BCD decrement with the full borrow chain resolved in one step; 00:00 stays 00:00
  assign dec = cnt[3:0] != 4'd0 ? cnt - 16'd1 :
               cnt[7:4] != 4'd0 ? {cnt[15:8], cnt[7:4] - 4'd1, 4'd9} :
               cnt[11:8] != 4'd0 ? {cnt[15:12], cnt[11:8] - 4'd1, 8'h59} :
               cnt[15:12] != 4'd0 ? {cnt[15:12] - 4'd1, 12'h959} : 16'h0;
  assign tick = state == RUN && presc == LAST;
  always_comb begin
    state_n = state inside {IDLE, RUN, PAUSE, DONE} ? state : IDLE;
    cnt_n = cnt;
    pre_n = pre;
    presc_n = presc;
    alarm_n = alarm_q;
    acnt_n = acnt;
    if (state == RUN) begin
      presc_n = tick ? '0 : presc + 1'b1;
      if (tick) begin
        cnt_n = dec;
        if (dec == 16'h0) begin
          state_n = DONE;
          alarm_n = ALARM_ON;
          acnt_n = '0;
        end
      end
    end
    // alarm phase is taken from the free-running prescaler; acnt counts elapsed ticks
    if (ALARM_ON && state == DONE) begin
      presc_n = presc == LAST ? '0 : presc + 1'b1;
      if (acnt != AW'(ALARM_SEC)) begin
        alarm_n = (presc == HALF || presc == LAST) ? ~alarm_q : alarm_q;
        if (presc == LAST) begin
          acnt_n = acnt + 1'b1;
          if (acnt == AW'(ALARM_SEC - 1)) alarm_n = 1'b0;
        end
      end
    end
    // highest asserted command wins; an inapplicable one is simply dropped
    if (bus.cancel) begin
      state_n = IDLE;
      cnt_n = pre;
      presc_n = '0;
      alarm_n = 1'b0;
    end else if (bus.load) begin
      if (state != RUN) begin
        pre_n = ld;
        cnt_n = ld;
        alarm_n = 1'b0;
        if (state == DONE) state_n = IDLE;
      end
    end else if (bus.start) begin
      if (state == IDLE && cnt != 16'h0) begin
        state_n = RUN;
        presc_n = '0;
      end else if (state == DONE) begin
        alarm_n = 1'b0;
        acnt_n = AW'(ALARM_SEC);
        if (pre != 16'h0) begin
          state_n = RUN;
          cnt_n = pre;
          presc_n = '0;
        end
      end
    end else if (bus.pause) begin
      // a tick reaching 00:00 on the same edge takes precedence over pausing
      state_n = state == RUN && state_n != DONE ? PAUSE : state == PAUSE ? RUN : state_n;
    end
    done_n = state_n == DONE && state != DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      pre <= '0;
      presc <= '0;
      acnt <= '0;
      done_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pre <= pre_n;
      presc <= presc_n;
      acnt <= acnt_n;
      done_q <= done_n;
      alarm_q <= alarm_n;
    end
  end
  assign {bus.mDecimal, bus.mUnit, bus.sDecimal, bus.sUnit} = cnt;
  assign bus.state_o = state;
  assign bus.done = done_q;
  assign bus.alarm = alarm_q;
endmodule
